// File: rtl/demod_frame_ctrl.sv
// demod_frame_ctrl: sequencing controller for the QPSK demodulator datapath.
// Enables the datapath, produces the bit-rate sample strobe, masks filter
// warm-up, hunts for the sync word and then hands out a fixed-length payload
// before re-arming the search for the next frame.
module demod_frame_ctrl #(
  parameter int                  CYCLES_PER_BIT = 8,
  parameter int                  WARMUP_CYCLES  = 64,
  parameter int                  SYNC_LEN       = 16,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD      = 16'hF0B4,
  parameter int                  PAYLOAD_BITS   = 128,
  parameter int                  SEARCH_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       demod_bit,
  output logic       dp_en,
  output logic       bit_strobe,
  output logic       data_out,
  output logic       data_valid,
  output logic       frame_start,
  output logic       frame_done,
  output logic       locked,
  output logic       timeout,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WARMUP  = 2'd1,
    SEARCH  = 2'd2,
    PAYLOAD = 2'd3
  } state_t;

  localparam int TW = $clog2(CYCLES_PER_BIT) + 1;
  localparam int WW = $clog2(WARMUP_CYCLES) + 1;
  localparam int SW = $clog2(SEARCH_TIMEOUT) + 1;
  localparam int PW = $clog2(PAYLOAD_BITS) + 1;

  localparam logic [TW-1:0] TIMER_LAST   = TW'(CYCLES_PER_BIT - 1);
  localparam logic [WW-1:0] WARMUP_LAST  = WW'(WARMUP_CYCLES - 1);
  localparam logic [SW-1:0] SYNC_LEN_C   = SW'(SYNC_LEN);
  localparam logic [SW-1:0] TIMEOUT_C    = SW'(SEARCH_TIMEOUT);
  localparam logic [PW-1:0] PAYLOAD_C    = PW'(PAYLOAD_BITS);

  state_t              state_reg;
  logic [TW-1:0]       timer_reg;
  logic [WW-1:0]       warm_cnt_reg;
  logic [SW-1:0]       srch_cnt_reg;
  logic [PW-1:0]       pay_cnt_reg;
  // Only the newest SYNC_LEN-1 bits need storing: the oldest bit of the
  // window is shifted out on the same strobe that completes a comparison.
  logic [SYNC_LEN-2:0] sr_reg;
  logic                data_out_reg;
  logic                data_valid_reg;
  logic                frame_start_reg;
  logic                frame_done_reg;
  logic                timeout_reg;

  logic [SYNC_LEN-1:0] sr_next;
  logic [SW-1:0]       srch_cnt_next;
  logic [PW-1:0]       pay_cnt_next;
  logic                sync_hit;

  // Strobe, candidate window and match decision for the current bit.
  always_comb begin
    dp_en         = (state_reg != IDLE);
    bit_strobe    = dp_en && (timer_reg == TIMER_LAST);
    sr_next       = {sr_reg, demod_bit};
    srch_cnt_next = srch_cnt_reg + 1'b1;
    pay_cnt_next  = pay_cnt_reg + 1'b1;
    // The count includes the current bit, so a partly filled window never matches.
    sync_hit      = (sr_next == SYNC_WORD) && (srch_cnt_next >= SYNC_LEN_C);
  end

  // Frame FSM with bit timer, counters and registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      timer_reg       <= '0;
      warm_cnt_reg    <= '0;
      srch_cnt_reg    <= '0;
      pay_cnt_reg     <= '0;
      sr_reg          <= '0;
      data_out_reg    <= 1'b0;
      data_valid_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      frame_done_reg  <= 1'b0;
      timeout_reg     <= 1'b0;
    end else begin
      frame_start_reg <= 1'b0;
      frame_done_reg  <= 1'b0;
      data_valid_reg  <= 1'b0;
      if (dp_en) begin
        timer_reg <= (timer_reg == TIMER_LAST) ? '0 : timer_reg + 1'b1;
      end
      if (stop) begin
        // Abort wins over everything; timeout flag is deliberately kept.
        state_reg    <= IDLE;
        timer_reg    <= '0;
        warm_cnt_reg <= '0;
        srch_cnt_reg <= '0;
        pay_cnt_reg  <= '0;
        sr_reg       <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start) begin
              state_reg    <= WARMUP;
              timeout_reg  <= 1'b0;
              timer_reg    <= '0;
              warm_cnt_reg <= '0;
              srch_cnt_reg <= '0;
              pay_cnt_reg  <= '0;
              sr_reg       <= '0;
            end
          end
          WARMUP: begin
            warm_cnt_reg <= warm_cnt_reg + 1'b1;
            if (warm_cnt_reg == WARMUP_LAST) begin
              state_reg <= SEARCH;
            end
          end
          SEARCH: begin
            if (bit_strobe) begin
              sr_reg       <= sr_next[SYNC_LEN-2:0];
              srch_cnt_reg <= srch_cnt_next;
              if (sync_hit) begin
                state_reg       <= PAYLOAD;
                frame_start_reg <= 1'b1;
              end else if (srch_cnt_next == TIMEOUT_C) begin
                state_reg   <= IDLE;
                timeout_reg <= 1'b1;
                timer_reg   <= '0;
              end
            end
          end
          PAYLOAD: begin
            if (bit_strobe) begin
              data_out_reg   <= demod_bit;
              data_valid_reg <= 1'b1;
              pay_cnt_reg    <= pay_cnt_next;
              if (pay_cnt_next == PAYLOAD_C) begin
                // Re-arm the hunt; the bit timer keeps its phase.
                frame_done_reg <= 1'b1;
                state_reg      <= SEARCH;
                sr_reg         <= '0;
                srch_cnt_reg   <= '0;
                pay_cnt_reg    <= '0;
              end
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign data_out    = data_out_reg;
  assign data_valid  = data_valid_reg;
  assign frame_start = frame_start_reg;
  assign frame_done  = frame_done_reg;
  assign timeout     = timeout_reg;
  assign locked      = (state_reg == PAYLOAD);
  assign state       = state_reg;

endmodule

// File: doc/demod_frame_ctrl.md
Name: demod_frame_ctrl

Overview:
- Sequencing controller for the QPSK demodulator datapath (I/Q extraction, I/Q filters, decision, I/Q combine).
- Gates the datapath, generates the bit-rate sampling strobe, masks filter warm-up and hunts for a sync word in the combined bit stream.
- Once the sync word is found, delivers a fixed-length payload with valid strobes, then re-arms for the next frame.

Parameters:
- CYCLES_PER_BIT, 8, clk cycles per demodulated bit; must be >= 2.
- WARMUP_CYCLES, 64, cycles output is masked after start (filter fill plus pipeline delay).
- SYNC_LEN, 16, sync word length in bits.
- SYNC_WORD, 16'hF0B4, sync pattern; the MSB is the first bit received.
- PAYLOAD_BITS, 128, payload bits delivered per frame.
- SEARCH_TIMEOUT, 1024, bits examined in SEARCH without a match before aborting.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  1-cycle request to begin reception; honoured only in IDLE.
- stop  in  1  abort to IDLE from any state.
- demod_bit  in  1  serial demodulated bit from the combiner.
- dp_en  out  1  datapath enable.
- bit_strobe  out  1  1-cycle pulse marking the bit sample instant.
- data_out  out  1  payload bit.
- data_valid  out  1  1-cycle qualifier for data_out.
- frame_start  out  1  1-cycle pulse on sync detect.
- frame_done  out  1  1-cycle pulse after the last payload bit.
- locked  out  1  high while in PAYLOAD.
- timeout  out  1  sticky search-timeout flag.
- state  out  2  IDLE=0, WARMUP=1, SEARCH=2, PAYLOAD=3.

Behaviour:
- Reset: every output is 0, state=IDLE, all counters and the shift register are 0.
- Bit timer:
  - Counts 0..CYCLES_PER_BIT-1 and wraps while dp_en=1; held at 0 while dp_en=0.
  - Reset to 0 on the IDLE->WARMUP transition.
  - bit_strobe is combinational: dp_en=1 and timer=CYCLES_PER_BIT-1.
  - demod_bit is sampled only in a strobe cycle.
- dp_en=1 in WARMUP, SEARCH and PAYLOAD; 0 in IDLE.
- IDLE:
  - On start (and stop=0): go to WARMUP, clear timeout, clear all counters.
  - start in any other state is ignored.
- WARMUP:
  - Cycle counter increments each cycle; at WARMUP_CYCLES-1 go to SEARCH.
  - Strobes during WARMUP are discarded.
- SEARCH:
  - On each strobe: shift register <= {sr[SYNC_LEN-2:0], demod_bit}; search bit count increments.
  - Match condition: the updated value equals SYNC_WORD and the bit count is >= SYNC_LEN. The count includes the current bit, so a partially filled register never matches.
  - On a match: go to PAYLOAD and assert frame_start in the next cycle.
  - Otherwise, when the count reaches SEARCH_TIMEOUT: go to IDLE, set timeout.
- PAYLOAD:
  - On each strobe: data_out <= demod_bit and data_valid=1, both registered and visible the cycle after the strobe.
  - The payload counter increments on each strobe.
  - On the PAYLOAD_BITS-th bit: frame_done pulses together with that bit's data_valid.
  - Then go to SEARCH with the shift register, search count and payload count cleared. The bit timer keeps running without a phase reset.
- stop:
  - Has priority over start and over every transition; IDLE is entered on the next edge.
  - A data_valid already registered in the stop cycle still appears; none after.
  - timeout is left unchanged.
- Sync match and timeout on the same bit: the match wins.
- Coincident bit-count and payload-count limits cannot occur, because the states are exclusive.
- Mid-operation rst_n assertion forces the reset values immediately, independent of clk.
- Counter widths are $clog2 of each limit plus 1; no wrap-around occurs inside a state.

Test Plan:
All tests use CYCLES_PER_BIT=4, WARMUP_CYCLES=8, SYNC_LEN=8, SYNC_WORD=8'hA5, PAYLOAD_BITS=16, SEARCH_TIMEOUT=32.
- Reset/idle: hold rst_n=0, then release with no start -> every output stays 0 and state=0 for 100 cycles.
- Warm-up and strobe:
  - Stimulus: start pulse.
  - Required: dp_en=1 the next cycle; state=1 for exactly 8 cycles, then 2.
  - Required: bit_strobe has period 4, first pulse 4 cycles after start is accepted.
- Sync plus payload:
  - Stimulus: bits 0,1,1 then 10100101, then payload 16'hC3A5 (MSB first).
  - Required: frame_start pulses once; locked=1; 16 data_valid pulses carrying 1100001110100101.
  - Required: frame_done coincides with the 16th valid; then state=2.
- Back-to-back frames: a second A5 sync immediately after the payload -> a second frame_start without returning to IDLE.
- Timeout: 32 bits of constant 0 in SEARCH -> state=0, timeout=1, dp_en=0. A subsequent start clears timeout.
- Stop and priority:
  - stop at payload bit 5 -> IDLE next cycle, no further data_valid.
  - start and stop in the same cycle while in IDLE -> remains IDLE.
  - rst_n pulsed mid-SEARCH -> all outputs are 0 asynchronously.
